// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared mode/state encodings and default LFSR taps for seq_gen_multi
package seq_gen_pkg;

    typedef enum logic [1:0] {
        FIB   = 2'd0,
        ARITH = 2'd1,
        LFSR  = 2'd2,
        GRAY  = 2'd3
    } seq_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

endpackage

// File: rtl/seq_next_term.sv
// seq_next_term: combinational successor of the current sequence term
//   mode_i      selected sequence
//   first_i     current term is t0 (FIB successor is then the t1 seed, not a sum)
//   cur_i       presented term
//   aux_i       FIB: previous term; GRAY: binary count behind the presented code
//   step_i      FIB t1 seed / ARITH step
//   taps_i      Galois feedback mask
//   next_o      next term
//   next_aux_o  next value for aux
//   carry_o     FIB/ARITH sum carried out of WIDTH
module seq_next_term
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  seq_mode_e        mode_i,
    input  logic             first_i,
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] aux_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0] taps_i,
    output logic [WIDTH-1:0] next_o,
    output logic [WIDTH-1:0] next_aux_o,
    output logic             carry_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] gray_cnt;
    logic             fib_seed;

    always_comb begin
        sum        = {1'b0, cur_i} + {1'b0, (mode_i == FIB) ? aux_i : step_i};
        gray_cnt   = aux_i + 1'b1;
        fib_seed   = (mode_i == FIB) && first_i;
        next_o     = (mode_i == GRAY) ? gray_cnt ^ (gray_cnt >> 1) :
                     (mode_i == LFSR) ? (cur_i[0] ? (cur_i >> 1) ^ taps_i : cur_i >> 1) :
                     fib_seed         ? step_i : sum[WIDTH-1:0];
        next_aux_o = (mode_i == GRAY) ? gray_cnt : cur_i;
        carry_o    = ((mode_i == FIB) || (mode_i == ARITH)) && !fib_seed && sum[WIDTH];
    end

endmodule

// File: rtl/seq_gen_multi.sv
// seq_gen_multi: run-time selectable FIB/ARITH/LFSR/GRAY generator with valid/ready output
//   clk, reset   clock, synchronous active-high reset
//   start_i      start a run (IDLE only); mode_i/seed_a_i/seed_b_i/len_i captured then
//   abort_i      end a run without done_o
//   ready_i      consumer accepts seq_o when valid_o && ready_i
//   seq_o        current term; valid_o/busy_o high in RUN
//   done_o       one-cycle pulse after the last term of a bounded run
//   ovf_o        sticky FIB/ARITH carry-out, cleared by the next start
module seq_gen_multi
    import seq_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] seed_a_i,
    input  logic [WIDTH-1:0] seed_b_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] seq_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);

    seq_state_e       state_q, state_d;
    seq_mode_e        mode_q, mode_d, mode_in;
    logic [WIDTH-1:0] cur_q, cur_d, aux_q, aux_d, step_q, step_d;
    logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d, first_q, first_d;
    logic [WIDTH-1:0] nxt_term, nxt_aux;
    logic             carry;

    seq_next_term #(.WIDTH(WIDTH)) u_next (
        .mode_i     (mode_q),
        .first_i    (first_q),
        .cur_i      (cur_q),
        .aux_i      (aux_q),
        .step_i     (step_q),
        .taps_i     (LFSR_TAPS),
        .next_o     (nxt_term),
        .next_aux_o (nxt_aux),
        .carry_o    (carry)
    );

    assign mode_in = seq_mode_e'(mode_i);
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cur_d   = cur_q;
        aux_d   = aux_q;
        step_d  = step_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        first_d = first_q;
        unique case (state_q)
            IDLE: if (start_i) begin
                state_d = RUN;
                mode_d  = mode_in;
                step_d  = seed_b_i;
                len_d   = len_i;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                first_d = 1'b1;
                aux_d   = seed_a_i;
                // An all-zero LFSR seed would lock up, so it is replaced by 1
                cur_d   = (mode_in == LFSR) ? ((seed_a_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_a_i) :
                          (mode_in == GRAY) ? seed_a_i ^ (seed_a_i >> 1) : seed_a_i;
            end
            RUN: if (abort_i) begin
                state_d = IDLE;
            end else if (ready_i) begin
                cnt_d = cnt_inc;
                // The final term stays on seq_o so IDLE shows the last presented value
                if ((len_q != '0) && (cnt_inc == len_q)) begin
                    state_d = DONE;
                end else begin
                    cur_d   = nxt_term;
                    aux_d   = nxt_aux;
                    first_d = 1'b0;
                    ovf_d   = ovf_q | carry;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= FIB;
            cur_q   <= '0;
            aux_q   <= '0;
            step_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cur_q   <= cur_d;
            aux_q   <= aux_d;
            step_q  <= step_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
        end
    end

    assign seq_o   = cur_q;
    assign valid_o = (state_q == RUN);
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_seq_gen_multi.sv
// tb_seq_gen_multi: directed stimulus, per-cycle model comparison plus literal term checks
module tb_seq_gen_multi;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [31:0] seed_a_i = '0;
    logic [31:0] seed_b_i = '0;
    logic [15:0] len_i = '0;
    logic        ready_i = 1'b0;
    logic [31:0] seq_o;
    logic        valid_o, busy_o, done_o, ovf_o;

    int tests = 0;
    int fails = 0;
    bit armed = 0;
    logic [31:0] acc[$];
    logic [31:0] exp_q[$];

    seq_gen_multi dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .mode_i   (mode_i),
        .seed_a_i (seed_a_i),
        .seed_b_i (seed_b_i),
        .len_i    (len_i),
        .ready_i  (ready_i),
        .seq_o    (seq_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    // k-th term straight from the sequence definitions
    function automatic logic [31:0] term_at(input int m, input logic [31:0] a, b, input int k);
        logic [31:0] p, c, x, g;
        if (m == 1) return a + b * 32'(k);
        if (m == 3) begin
            g = a + 32'(k);
            return g ^ (g >> 1);
        end
        if (m == 2) begin
            x = (a == 0) ? 32'd1 : a;
            for (int i = 0; i < k; i++) x = x[0] ? (x >> 1) ^ TAPS : x >> 1;
            return x;
        end
        if (k == 0) return a;
        p = a;
        c = b;
        for (int i = 2; i <= k; i++) begin
            x = p + c;
            p = c;
            c = x;
        end
        return c;
    endfunction

    // whether any sum producing terms 1..k carried out of 32 bits
    function automatic logic ovf_upto(input int m, input logic [31:0] a, b, input int k);
        logic [32:0] s;
        logic [31:0] p, c;
        logic o = 1'b0;
        if (m == 1) begin
            c = a;
            for (int i = 1; i <= k; i++) begin
                s = {1'b0, c} + {1'b0, b};
                o |= s[32];
                c = s[31:0];
            end
        end else if (m == 0) begin
            p = a;
            c = b;
            for (int i = 2; i <= k; i++) begin
                s = {1'b0, p} + {1'b0, c};
                o |= s[32];
                p = c;
                c = s[31:0];
            end
        end
        return o;
    endfunction

    int          m_phase = 0;
    int          m_mode = 0;
    int          m_k = 0;
    int          m_len = 0;
    logic [31:0] m_a = '0, m_b = '0, m_seq = '0;
    logic        m_ovf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_seq   <= '0;
            m_ovf   <= 1'b0;
        end else if (m_phase == 0) begin
            if (start_i) begin
                m_phase <= 1;
                m_mode  <= int'(mode_i);
                m_a     <= seed_a_i;
                m_b     <= seed_b_i;
                m_len   <= int'(len_i);
                m_k     <= 0;
                m_ovf   <= 1'b0;
                m_seq   <= term_at(int'(mode_i), seed_a_i, seed_b_i, 0);
            end
        end else if (m_phase == 1) begin
            if (abort_i) m_phase <= 0;
            else if (ready_i) begin
                if (m_len != 0 && m_k + 1 == m_len) m_phase <= 2;
                else begin
                    m_k   <= m_k + 1;
                    m_seq <= term_at(m_mode, m_a, m_b, m_k + 1);
                    m_ovf <= ovf_upto(m_mode, m_a, m_b, m_k + 1);
                end
            end
        end else begin
            m_phase <= 0;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("valid", 32'(valid_o), 32'(m_phase == 1));
            chk("busy", 32'(busy_o), 32'(m_phase == 1));
            chk("done", 32'(done_o), 32'(m_phase == 2));
            chk("ovf", 32'(ovf_o), 32'(m_ovf));
            chk("seq", seq_o, m_seq);
        end
        if (!reset && valid_o && ready_i && !abort_i) acc.push_back(seq_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] a, b, input logic [15:0] l);
        mode_i   = m;
        seed_a_i = a;
        seed_b_i = b;
        len_i    = l;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic run(input logic [1:0] m, input logic [31:0] a, b, input logic [15:0] l, input bit toggle);
        bit seen = 0;
        acc.delete();
        start_run(m, a, b, l);
        for (int c = 0; c < 100 && !seen; c++) begin
            ready_i = toggle ? (c % 2 == 0) : 1'b1;
            tick();
            if (done_o) seen = 1;
        end
        chk("done_reached", 32'(seen), 32'd1);
        ready_i = 1'b1;
        tick();
    endtask

    task automatic chk_q(input string n);
        chk({n, "_count"}, 32'(acc.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc.size(); i++) chk(n, acc[i], exp_q[i]);
    endtask

    initial begin
        tick();
        tick();
        armed = 1;
        chk("rst_seq", seq_o, 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        reset = 1'b0;
        tick();

        run(2'd0, 32'd0, 32'd1, 16'd10, 0);
        exp_q = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
        chk_q("fib_terms");
        chk("fib_ovf", 32'(ovf_o), 32'd0);
        chk("fib_idle_hold", seq_o, 32'd34);

        run(2'd1, 32'hFFFF_FFF0, 32'h10, 16'd3, 0);
        exp_q = '{32'hFFFF_FFF0, 32'h0, 32'h10};
        chk_q("arith_terms");
        chk("arith_ovf_sticky", 32'(ovf_o), 32'd1);

        run(2'd2, 32'd0, 32'd0, 16'd3, 0);
        exp_q = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
        chk_q("lfsr_terms");
        chk("lfsr_ovf_cleared", 32'(ovf_o), 32'd0);

        run(2'd3, 32'd0, 32'd0, 16'd5, 1);
        exp_q = '{32'd0, 32'd1, 32'd3, 32'd2, 32'd6};
        chk_q("gray_terms");

        acc.delete();
        start_run(2'd0, 32'd0, 32'd1, 16'd0);
        ready_i = 1'b1;
        repeat (7) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_valid", 32'(valid_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        exp_q = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
        chk_q("abort_terms");
        run(2'd0, 32'd5, 32'd7, 16'd2, 0);
        exp_q = '{32'd5, 32'd7};
        chk_q("restart_terms");

        acc.delete();
        start_run(2'd1, 32'd1, 32'd1, 16'd0);
        ready_i = 1'b1;
        tick();
        tick();
        mode_i   = 2'd2;
        seed_a_i = 32'd99;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_seq", seq_o, 32'd0);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        chk_q("midrst_terms");
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
